muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Sequencer for the EXE-stage HI/LO arithmetic resources.
- Accepts one MULT/MULTU/DIV/DIVU request per EXE instruction.
- Drives the existing multi-cycle `multiply` unit through its begin/end handshake and runs an internal 32-iteration restoring divider.
- Holds the 64-bit HI/LO result until the pipeline accepts it. Gives the EXE stage one busy/valid pair to build `EXE_over`, and supports cancellation on exception flush.

Parameters:
- DIV_ITER, 32, number of divider iterations (one quotient bit per cycle).
- DIV0_Q, 32'hFFFF_FFFF, quotient returned for division by zero.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  EXE stage valid and instruction is mul/div
- op_mul  in  1  request is MULT/MULTU
- op_div  in  1  request is DIV/DIVU
- op_sign  in  1  signed operation
- op_a  in  32  operand 1 (rs)
- op_b  in  32  operand 2 (rt)
- flush  in  1  cancel any operation in flight (exception/eret)
- res_ack  in  1  EXE->MEM handoff taken this cycle
- mult_begin  out  1  level request to `multiply` unit
- mult_end  in  1  `multiply` result ready
- product  in  64  `multiply` result
- busy  out  1  state != IDLE
- res_valid  out  1  result held and valid
- res_hi  out  32  HI value (product[63:32] / remainder)
- res_lo  out  32  LO value (product[31:0] / quotient)

Behaviour:
- Reset (async, rst=1): state=IDLE; mult_begin=0, busy=0, res_valid=0, res_hi=0, res_lo=0; divider counter and registers cleared.
- States: IDLE, MUL_WAIT, DIV_RUN, DONE.
- IDLE:
  - op_valid & op_mul -> MUL_WAIT.
  - op_valid & op_div -> DIV_RUN: latch |a| and |b| (magnitudes when op_sign, raw otherwise), latch sign bits, counter=0.
  - op_mul & op_div both set: mul wins (decoder never issues this).
  - op_div with op_b==0 -> DONE directly (next edge) with res_lo=DIV0_Q, res_hi=op_a.
- MUL_WAIT:
  - mult_begin=1 for the whole state.
  - On mult_end: capture product into res_hi/res_lo and go to DONE. mult_begin is 0 from the next cycle.
  - Operands are not latched; the EXE stage holds op_a/op_b stable while busy.
- DIV_RUN:
  - Each cycle: rem = {rem[30:0], dividend_msb}; if rem >= divisor then rem -= divisor and q_bit=1; counter++.
  - After DIV_ITER cycles -> DONE.
  - Sign fixup is applied when loading res_*: quotient negated if a31^b31, remainder negated if a31 (signed only).
  - 0x80000000 / -1 signed -> q=0x80000000, r=0 (falls out of magnitude math).
- DONE:
  - res_valid=1; res_hi/res_lo stable.
  - On res_ack -> IDLE. The next op is accepted no earlier than the following cycle.
- Latency:
  - Mul: res_valid rises the cycle after mult_end.
  - Div: res_valid rises exactly DIV_ITER+1 cycles after the accepting edge; divide-by-zero takes 1 cycle.
- busy = (state != IDLE). EXE_over for mul/div = res_valid.
- op_valid outside IDLE is ignored (no re-launch while running or holding).
- flush:
  - Highest priority in any state: next edge -> IDLE, res_valid=0, mult_begin=0, counter=0.
  - A flush coinciding with res_ack or a new op is still a flush; the op is dropped.
  - A late mult_end after flush is ignored in IDLE.
- res_hi/res_lo retain their last value in IDLE. Only res_valid qualifies them.

Decomposition:
- Package muldiv_pkg:
  - state encoding constants (IDLE=2'd0, MUL_WAIT=2'd1, DIV_RUN=2'd2, DONE=2'd3)
  - DIV_ITER and DIV0_Q
  - 5-bit counter width
- Sub-module div_core:
  - holds the remainder/quotient shift registers and counter; performs one restoring step per cycle.
  - interface: start, a_mag, b_mag, step_en, clear, q, r, last.
- muldiv_ctrl keeps the FSM, sign handling, multiply handshake and result registers.

Test Plan:
- Unsigned DIVU 100/7 -> res_valid 33 cycles after accept; res_lo=14, res_hi=2; held until res_ack pulse, then busy=0 next cycle.
- Signed DIV -7/2 (0xFFFFFFF9/2) -> res_lo=0xFFFFFFFD, res_hi=0xFFFFFFFF; also 0x80000000/0xFFFFFFFF -> res_lo=0x80000000, res_hi=0.
- DIVU 5/0 -> res_valid on 2nd cycle after accept; res_lo=0xFFFFFFFF, res_hi=5.
- MULTU with model asserting mult_end 3 cycles after mult_begin, product=64'h1_FFFFFFFE -> mult_begin high exactly while MUL_WAIT; res_hi=1, res_lo=0xFFFFFFFE; res_ack withheld 5 cycles -> values stable, no relaunch.
- Flush at DIV_RUN iteration 10 -> busy=0 and res_valid=0 the next cycle; a following DIVU 9/3 yields q=3, r=0 in 33 cycles (no stale state).
- Async rst asserted mid-MUL_WAIT (between clock edges) -> mult_begin, busy, res_valid drop immediately; mult_end after release is ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO mul/div sequencer.
// Holds the FSM encoding, divider sizing and a small negate helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int          DIV_ITER = 32;
  localparam logic [31:0] DIV0_Q   = 32'hFFFF_FFFF;
  localparam int          CNT_W    = 5;

  function automatic logic [31:0] neg_if(
    input logic        c,
    input logic [31:0] v
  );
    return c ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// Restoring divider datapath: one quotient bit per step_en cycle.
// Ports: start/a_mag/b_mag load, step_en, clear, q, r, last.
module div_core
  import muldiv_pkg::*;
#(
  parameter int ITER = DIV_ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  input  logic        step_en,
  input  logic        clear,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        last
);

  logic [31:0]      quo;
  logic [31:0]      rem;
  logic [31:0]      dsr;
  logic [CNT_W-1:0] cnt;
  logic             fin;
  logic [32:0]      trial;

  // 33-bit trial keeps the shifted remainder exact for large divisors.
  assign trial = {rem, quo[31]} - {1'b0, dsr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
      cnt <= '0;
      fin <= 1'b0;
    end else if (clear) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
      cnt <= '0;
      fin <= 1'b0;
    end else if (start) begin
      quo <= a_mag;
      rem <= '0;
      dsr <= b_mag;
      cnt <= '0;
      fin <= 1'b0;
    end else if (step_en) begin
      if (!trial[32]) begin
        rem <= trial[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= {rem[30:0], quo[31]};
        quo <= {quo[30:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
      fin <= (cnt == CNT_W'(ITER - 1));
    end
  end

  assign q    = quo;
  assign r    = rem;
  assign last = fin;

endmodule

// File: rtl/muldiv_ctrl.sv
// EXE-stage HI/LO sequencer: multiply handshake, divider, result hold.
// Ports: op_* request, flush, res_ack, mult_* handshake, busy/res_*.
module muldiv_ctrl #(
  parameter int          DIV_ITER = muldiv_pkg::DIV_ITER,
  parameter logic [31:0] DIV0_Q   = muldiv_pkg::DIV0_Q
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_mul,
  input  logic        op_div,
  input  logic        op_sign,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        res_ack,
  output logic        mult_begin,
  input  logic        mult_end,
  input  logic [63:0] product,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);
  import muldiv_pkg::*;

  state_t      state;
  state_t      state_nx;
  logic        a_neg;
  logic        b_neg;
  logic        b_zero;
  logic        start;
  logic        step_en;
  logic        last;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q;
  logic [31:0] r;

  assign start = (state == IDLE) && op_valid && !op_mul
               && op_div && !flush;

  assign a_mag = neg_if(op_sign & op_a[31], op_a);
  assign b_mag = neg_if(op_sign & op_b[31], op_b);

  // Divide-by-zero skips the iterations entirely.
  assign step_en = (state == DIV_RUN) && !b_zero && !last;

  div_core #(
    .ITER(DIV_ITER)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .step_en(step_en),
    .clear  (flush),
    .q      (q),
    .r      (r),
    .last   (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (op_valid && op_mul)      state_nx = MUL_WAIT;
        else if (op_valid && op_div) state_nx = DIV_RUN;
      end
      MUL_WAIT: if (mult_end)          state_nx = DONE;
      DIV_RUN:  if (b_zero || last)    state_nx = DONE;
      DONE:     if (res_ack)           state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_comb begin
    busy       = (state != IDLE);
    mult_begin = (state == MUL_WAIT);
    res_valid  = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      b_zero <= 1'b0;
    end else if (start) begin
      a_neg  <= op_sign & op_a[31];
      b_neg  <= op_sign & op_b[31];
      b_zero <= (op_b == 32'd0);
    end
  end

  // EXE holds op_a stable while busy, so the div-by-zero HI comes from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_hi <= '0;
      res_lo <= '0;
    end else if (!flush) begin
      if (state == MUL_WAIT && mult_end) begin
        res_hi <= product[63:32];
        res_lo <= product[31:0];
      end else if (state == DIV_RUN && b_zero) begin
        res_hi <= op_a;
        res_lo <= DIV0_Q;
      end else if (state == DIV_RUN && last) begin
        res_hi <= neg_if(a_neg, r);
        res_lo <= neg_if(a_neg ^ b_neg, q);
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl.
// Directed plus random mul/div ops against an arithmetic reference.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_mul;
  logic        op_div;
  logic        op_sign;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        res_ack;
  logic        mult_begin;
  logic        mult_end;
  logic [63:0] product;
  logic        busy;
  logic        res_valid;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_mul    (op_mul),
    .op_div    (op_div),
    .op_sign   (op_sign),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .res_ack   (res_ack),
    .mult_begin(mult_begin),
    .mult_end  (mult_end),
    .product   (product),
    .busy      (busy),
    .res_valid (res_valid),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
    longint sa;
    longint sb;
    longint qq;
    longint rr;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!s) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qq = sa / sb;
    rr = sa % sb;
    return {rr[31:0], qq[31:0]};
  endfunction

  function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
    longint p;
    if (s) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int hold);
    logic [63:0] e;
    int n;
    e = ref_div(a, b, s);
    op_a = a; op_b = b; op_sign = s;
    op_mul = 1'b0; op_div = 1'b1; op_valid = 1'b1;
    tick();
    op_valid = 1'b0; op_div = 1'b0;
    chk("div_busy", 64'(busy), 64'd1);
    n = 0;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    chk("div_latency", 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
    chk("div_hi", 64'(res_hi), 64'(e[63:32]));
    chk("div_lo", 64'(res_lo), 64'(e[31:0]));
    if (hold > 0) begin
      repeat (hold) tick();
      chk("div_hold", {31'd0, res_valid, res_hi, res_lo},
          {31'd0, 1'b1, e});
    end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    chk("div_ack_idle", {62'd0, busy, res_valid}, 64'd0);
    chk("div_retain", {res_hi, res_lo}, e);
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int d, input int hold);
    logic [63:0] e;
    int nb;
    e = ref_mul(a, b, s);
    op_a = a; op_b = b; op_sign = s;
    op_mul = 1'b1; op_div = 1'b0; op_valid = 1'b1;
    tick();
    nb = 0;
    for (int i = 0; i < d; i++) begin
      if (mult_begin) nb++;
      tick();
    end
    if (mult_begin) nb++;
    mult_end = 1'b1;
    product = e;
    tick();
    mult_end = 1'b0;
    product = {$urandom, $urandom};
    chk("mul_begin_cycles", 64'(nb), 64'(d + 1));
    chk("mul_done", {62'd0, res_valid, mult_begin}, 64'd2);
    chk("mul_result", {res_hi, res_lo}, e);
    if (hold > 0) begin
      repeat (hold) tick();
      chk("mul_hold", {30'd0, busy, res_valid, res_hi, res_lo},
          {30'd0, 2'b11, e});
      chk("mul_no_relaunch", 64'(mult_begin), 64'd0);
    end
    op_valid = 1'b0; op_mul = 1'b0;
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    chk("mul_ack_idle", {62'd0, busy, res_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1;
    op_valid = 1'b0; op_mul = 1'b0; op_div = 1'b0; op_sign = 1'b0;
    op_a = '0; op_b = '0; flush = 1'b0; res_ack = 1'b0;
    mult_end = 1'b0; product = '0;
    #2;
    chk("reset_state", {29'd0, mult_begin, busy, res_valid, res_hi, res_lo},
        64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_div(32'd100, 32'd7, 1'b0, 3);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_div(32'd5, 32'd0, 1'b0, 0);
    run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0);
    run_mul(32'hFFFF_FFFF, 32'd2, 1'b0, 2, 5);

    // flush mid-divide, then a clean divide
    op_a = 32'd1000; op_b = 32'd3; op_sign = 1'b0;
    op_div = 1'b1; op_valid = 1'b1;
    tick();
    op_valid = 1'b0; op_div = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", {62'd0, busy, res_valid}, 64'd0);
    run_div(32'd9, 32'd3, 1'b0, 0);

    // flush beats a new op in IDLE
    op_a = 32'd8; op_b = 32'd2; op_div = 1'b1; op_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0; op_valid = 1'b0; op_div = 1'b0;
    chk("flush_drops_op", 64'(busy), 64'd0);

    // async reset inside MUL_WAIT
    op_a = 32'd3; op_b = 32'd4; op_mul = 1'b1; op_valid = 1'b1;
    tick();
    op_valid = 1'b0; op_mul = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {29'd0, mult_begin, busy, res_valid, res_hi, res_lo},
        64'd0);
    #1 rst = 1'b0;
    mult_end = 1'b1;
    product = 64'h1234_5678_9ABC_DEF0;
    tick();
    mult_end = 1'b0;
    chk("late_mult_end", {61'd0, mult_begin, busy, res_valid}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
      run_div(ra, rb, 1'($urandom_range(0, 1)), 0);
    end
    for (int i = 0; i < 6; i++) begin
      run_mul($urandom, $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 4), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
